// File: rtl/ram_tdp_csoe_resp.sv
// True dual-port CS/OE RAM responder with same-address collision handling,
// saturating collision counter and post-reset ready handshake.
// Optional power-up clear sequence is enabled by defining RAM_TDP_INIT_CLEAR_EN.
module ram_tdp_csoe_resp #(
   parameter int AWIDTH      = 4,
   parameter int DWIDTH      = 8,
   parameter int CNT_WIDTH   = 8,
   parameter int WR_PRIORITY = 0,
   parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cs_0,
   input  logic                 oe_0,
   input  logic                 we_0,
   input  logic [AWIDTH-1:0]    addr_0,
   input  logic [DWIDTH-1:0]    din_0,
   output logic [DWIDTH-1:0]    dout_0,
   input  logic                 cs_1,
   input  logic                 oe_1,
   input  logic                 we_1,
   input  logic [AWIDTH-1:0]    addr_1,
   input  logic [DWIDTH-1:0]    din_1,
   output logic [DWIDTH-1:0]    dout_1,
   output logic                 ready,
   output logic                 collision,
   output logic [CNT_WIDTH-1:0] coll_cnt
);

   localparam int DEPTH = 2**AWIDTH;

`ifdef RAM_TDP_INIT_CLEAR_EN
   typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;
`else
   typedef enum logic [1:0] {ST_RESET, ST_READY} state_t;
`endif

   state_t state_reg;
   state_t state_next;

   logic [DWIDTH-1:0] mem [DEPTH];

   logic [1:0]        cs;
   logic [1:0]        oe;
   logic [1:0]        we;
   logic [1:0]        acc;
   logic [1:0]        wr_en;
   logic [AWIDTH-1:0] addr [2];
   logic [DWIDTH-1:0] din [2];
   logic [DWIDTH-1:0] rd_data_reg [2];
   logic [DWIDTH-1:0] dout [2];

   logic                 same_addr;
   logic                 coll_event;
   logic                 coll_ww;
   logic                 collision_reg;
   logic [CNT_WIDTH-1:0] coll_cnt_reg;

   assign cs      = {cs_1, cs_0};
   assign oe      = {oe_1, oe_0};
   assign we      = {we_1, we_0};
   assign addr[0] = addr_0;
   assign addr[1] = addr_1;
   assign din[0]  = din_0;
   assign din[1]  = din_1;

   assign ready = (state_reg == ST_READY);

   // ---------------------------------------------------------------
   // Ready FSM and optional clear walker
   // ---------------------------------------------------------------
`ifdef RAM_TDP_INIT_CLEAR_EN
   logic [AWIDTH-1:0] clr_addr_reg;
   logic [AWIDTH-1:0] clr_addr_next;
   logic              clr_en;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_RESET;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
`ifdef RAM_TDP_INIT_CLEAR_EN
      clr_en        = 1'b0;
      clr_addr_next = clr_addr_reg;
`endif
      case (state_reg)
         ST_RESET: begin
`ifdef RAM_TDP_INIT_CLEAR_EN
            state_next    = ST_CLEAR;
            clr_addr_next = '0;
`else
            state_next = ST_READY;
`endif
         end
`ifdef RAM_TDP_INIT_CLEAR_EN
         ST_CLEAR: begin
            clr_en        = 1'b1;
            clr_addr_next = clr_addr_reg + 1'b1;
            if (clr_addr_reg == AWIDTH'(DEPTH-1)) begin
               state_next = ST_READY;
            end
         end
`endif
         ST_READY: begin
            state_next = ST_READY;
         end
         default: begin
            state_next = ST_RESET;
         end
      endcase
   end

`ifdef RAM_TDP_INIT_CLEAR_EN
   // Restarting from address 0 on any reset, including mid-walk.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clr_addr_reg <= '0;
      end else begin
         clr_addr_reg <= clr_addr_next;
      end
   end
`endif

   // ---------------------------------------------------------------
   // Access qualification and collision detection
   // ---------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_acc
         assign acc[gi] = ready & cs[gi];
      end
   endgenerate

   assign same_addr  = (addr[0] == addr[1]);
   assign coll_event = acc[0] & acc[1] & same_addr & (we[0] | we[1]);
   assign coll_ww    = acc[0] & acc[1] & same_addr & we[0] & we[1];

   // The losing port of a same-address double write is suppressed.
   generate
      for (gi = 0; gi < 2; gi++) begin : g_wr_en
         assign wr_en[gi] = acc[gi] & we[gi] & ~(coll_ww & (WR_PRIORITY != gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         collision_reg <= 1'b0;
         coll_cnt_reg  <= '0;
      end else begin
         collision_reg <= coll_event;
         if (coll_event && (coll_cnt_reg != {CNT_WIDTH{1'b1}})) begin
            coll_cnt_reg <= coll_cnt_reg + 1'b1;
         end
      end
   end

   assign collision = collision_reg;
   assign coll_cnt  = coll_cnt_reg;

   // ---------------------------------------------------------------
   // Memory array: no reset, a reset edge blocks every write
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst_n) begin
`ifdef RAM_TDP_INIT_CLEAR_EN
         if (clr_en) begin
            mem[clr_addr_reg] <= INIT_VALUE;
         end
`endif
         if (wr_en[0]) begin
            mem[addr[0]] <= din[0];
         end
         if (wr_en[1]) begin
            mem[addr[1]] <= din[1];
         end
      end
   end

   // Registered reads see pre-edge contents, giving read-before-write.
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rd_data_reg[gi] <= '0;
            end else if (acc[gi] && !we[gi]) begin
               rd_data_reg[gi] <= mem[addr[gi]];
            end
         end

         assign dout[gi] = oe[gi] ? rd_data_reg[gi] : '0;
      end
   endgenerate

   assign dout_0 = dout[0];
   assign dout_1 = dout[1];

endmodule

// File: tb/tb_ram_tdp_csoe_resp.sv
// Directed self-checking bench for ram_tdp_csoe_resp; covers the clear
// sequence as well when compiled with RAM_TDP_INIT_CLEAR_EN.
module tb_ram_tdp_csoe_resp;

   localparam int AWIDTH    = 4;
   localparam int DWIDTH    = 8;
   localparam int CNT_WIDTH = 8;
   localparam int DEPTH     = 16;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 cs_0, oe_0, we_0;
   logic [AWIDTH-1:0]    addr_0;
   logic [DWIDTH-1:0]    din_0;
   logic [DWIDTH-1:0]    dout_0;
   logic                 cs_1, oe_1, we_1;
   logic [AWIDTH-1:0]    addr_1;
   logic [DWIDTH-1:0]    din_1;
   logic [DWIDTH-1:0]    dout_1;
   logic                 ready;
   logic                 collision;
   logic [CNT_WIDTH-1:0] coll_cnt;

   int checks = 0;
   int errors = 0;

   ram_tdp_csoe_resp #(
      .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .CNT_WIDTH(CNT_WIDTH),
      .WR_PRIORITY(0), .INIT_VALUE(8'hFF)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cs_0(cs_0), .oe_0(oe_0), .we_0(we_0), .addr_0(addr_0), .din_0(din_0), .dout_0(dout_0),
      .cs_1(cs_1), .oe_1(oe_1), .we_1(we_1), .addr_1(addr_1), .din_1(din_1), .dout_1(dout_1),
      .ready(ready), .collision(collision), .coll_cnt(coll_cnt)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cs_0 = 0; we_0 = 0; addr_0 = '0; din_0 = '0;
      cs_1 = 0; we_1 = 0; addr_1 = '0; din_1 = '0;
   endtask

   task automatic test_reset();
      rst_n = 0; oe_0 = 1; oe_1 = 1;
      cs_0 = 1; we_0 = 1; addr_0 = 4'd3; din_0 = 8'h99;
      cs_1 = 1; we_1 = 1; addr_1 = 4'd3; din_1 = 8'h98;
      cyc(); cyc(); cyc();
      checks++; if (dout_0 !== 8'h00) begin errors++; $display("FAIL reset_dout_0 got %h exp 00", dout_0); end
      checks++; if (dout_1 !== 8'h00) begin errors++; $display("FAIL reset_dout_1 got %h exp 00", dout_1); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
      checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision got %b exp 0", collision); end
      checks++; if (coll_cnt !== 8'd0) begin errors++; $display("FAIL reset_coll_cnt got %0d exp 0", coll_cnt); end
      $display("reset: dout_0=%h dout_1=%h ready=%b cnt=%0d", dout_0, dout_1, ready, coll_cnt);
      idle();
   endtask

`ifdef RAM_TDP_INIT_CLEAR_EN
   task automatic run_clear(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         cyc();
         checks++; if (ready !== 1'b0) begin errors++; $display("FAIL %s_ready_low cycle %0d got %b exp 0", tag, i, ready); end
      end
      cyc();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL %s_ready_high got %b exp 1", tag, ready); end
      $display("%s: ready rose after %0d edges", tag, DEPTH + 1);
      for (int i = 0; i < DEPTH; i++) begin
         cs_0 = 1; we_0 = 0; addr_0 = AWIDTH'(i);
         cs_1 = 1; we_1 = 0; addr_1 = AWIDTH'(DEPTH - 1 - i);
         cyc();
         checks++; if (dout_0 !== 8'hFF) begin errors++; $display("FAIL %s_read0 addr %0d got %h exp FF", tag, i, dout_0); end
         checks++; if (dout_1 !== 8'hFF) begin errors++; $display("FAIL %s_read1 addr %0d got %h exp FF", tag, DEPTH - 1 - i, dout_1); end
      end
      idle();
   endtask

   task automatic test_clear();
      rst_n = 1;
      run_clear("clear");
   endtask

   task automatic test_clear_restart();
      for (int i = 0; i < DEPTH; i++) begin
         cs_0 = 1; we_0 = 1; addr_0 = AWIDTH'(i); din_0 = 8'h00;
         cyc();
      end
      idle();
      rst_n = 0; cyc();
      rst_n = 1;
      for (int i = 0; i < 9; i++) cyc();
      rst_n = 0; cyc();
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL restart_ready_in_reset got %b exp 0", ready); end
      $display("restart: reset asserted at clear address 8");
      rst_n = 1;
      run_clear("restart");
   endtask
`else
   task automatic test_release();
      rst_n = 1;
      cyc();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", ready); end
      $display("release: ready=%b", ready);
   endtask
`endif

   task automatic test_write_read();
      cs_0 = 1; we_0 = 1; addr_0 = 4'd3; din_0 = 8'hA5;
      cyc();
      idle();
      cs_1 = 1; we_1 = 0; addr_1 = 4'd3; oe_1 = 1;
      cyc();
      checks++; if (dout_1 !== 8'hA5) begin errors++; $display("FAIL wr_rd_dout_1 got %h exp A5", dout_1); end
      checks++; if (collision !== 1'b0) begin errors++; $display("FAIL wr_rd_collision got %b exp 0", collision); end
      idle(); oe_1 = 0; #1;
      checks++; if (dout_1 !== 8'h00) begin errors++; $display("FAIL oe_off_dout_1 got %h exp 00", dout_1); end
      cyc(); oe_1 = 1; #1;
      checks++; if (dout_1 !== 8'hA5) begin errors++; $display("FAIL oe_late_dout_1 got %h exp A5", dout_1); end
      $display("write_read: addr 3 dout_1=%h", dout_1);
   endtask

   task automatic test_write_write();
      cs_0 = 1; we_0 = 1; addr_0 = 4'd7; din_0 = 8'h11;
      cs_1 = 1; we_1 = 1; addr_1 = 4'd7; din_1 = 8'h22;
      cyc();
      checks++; if (collision !== 1'b1) begin errors++; $display("FAIL ww_collision got %b exp 1", collision); end
      checks++; if (coll_cnt !== 8'd1) begin errors++; $display("FAIL ww_coll_cnt got %0d exp 1", coll_cnt); end
      cs_0 = 1; we_0 = 0; addr_0 = 4'd7;
      cs_1 = 1; we_1 = 0; addr_1 = 4'd7;
      cyc();
      checks++; if (collision !== 1'b0) begin errors++; $display("FAIL ww_pulse_end got %b exp 0", collision); end
      checks++; if (dout_0 !== 8'h11) begin errors++; $display("FAIL ww_read0 got %h exp 11", dout_0); end
      checks++; if (dout_1 !== 8'h11) begin errors++; $display("FAIL ww_read1 got %h exp 11", dout_1); end
      checks++; if (coll_cnt !== 8'd1) begin errors++; $display("FAIL rr_coll_cnt got %0d exp 1", coll_cnt); end
      $display("write_write: addr 7 = %h cnt=%0d", dout_0, coll_cnt);
      idle();
   endtask

   task automatic test_read_during_write();
      cs_1 = 1; we_1 = 1; addr_1 = 4'd5; din_1 = 8'h33;
      cyc();
      cs_0 = 1; we_0 = 1; addr_0 = 4'd5; din_0 = 8'h44;
      cs_1 = 1; we_1 = 0; addr_1 = 4'd5;
      cyc();
      checks++; if (dout_1 !== 8'h33) begin errors++; $display("FAIL rdw_old_data got %h exp 33", dout_1); end
      checks++; if (collision !== 1'b1) begin errors++; $display("FAIL rdw_collision got %b exp 1", collision); end
      checks++; if (coll_cnt !== 8'd2) begin errors++; $display("FAIL rdw_coll_cnt got %0d exp 2", coll_cnt); end
      idle();
      cs_1 = 1; we_1 = 0; addr_1 = 4'd5;
      cyc();
      checks++; if (dout_1 !== 8'h44) begin errors++; $display("FAIL rdw_new_data got %h exp 44", dout_1); end
      $display("read_during_write: old=33 new=%h cnt=%0d", dout_1, coll_cnt);
      idle();
   endtask

   task automatic test_back_to_back();
      cs_0 = 1; we_0 = 1; addr_0 = 4'd2; din_0 = 8'h5A;
      cyc();
      cs_0 = 1; we_0 = 0; addr_0 = 4'd2;
      cs_1 = 1; we_1 = 0; addr_1 = 4'd2;
      cyc();
      checks++; if (dout_0 !== 8'h5A) begin errors++; $display("FAIL rr_read0 got %h exp 5A", dout_0); end
      checks++; if (dout_1 !== 8'h5A) begin errors++; $display("FAIL rr_read1 got %h exp 5A", dout_1); end
      checks++; if (collision !== 1'b0) begin errors++; $display("FAIL rr_collision got %b exp 0", collision); end
      cs_0 = 1; we_0 = 1; addr_0 = 4'd1; din_0 = 8'h01;
      cs_1 = 1; we_1 = 1; addr_1 = 4'd9; din_1 = 8'h09;
      cyc();
      checks++; if (collision !== 1'b0) begin errors++; $display("FAIL diff_addr_collision got %b exp 0", collision); end
      checks++; if (coll_cnt !== 8'd2) begin errors++; $display("FAIL diff_addr_coll_cnt got %0d exp 2", coll_cnt); end
      cs_0 = 1; we_0 = 0; addr_0 = 4'd9;
      cs_1 = 1; we_1 = 0; addr_1 = 4'd1;
      cyc();
      checks++; if (dout_0 !== 8'h09) begin errors++; $display("FAIL b2b_read9 got %h exp 09", dout_0); end
      checks++; if (dout_1 !== 8'h01) begin errors++; $display("FAIL b2b_read1 got %h exp 01", dout_1); end
      addr_0 = 4'd1; addr_1 = 4'd9;
      cyc();
      checks++; if (dout_0 !== 8'h01) begin errors++; $display("FAIL b2b_swap0 got %h exp 01", dout_0); end
      checks++; if (dout_1 !== 8'h09) begin errors++; $display("FAIL b2b_swap1 got %h exp 09", dout_1); end
      $display("back_to_back: addr1=%h addr9=%h cnt=%0d", dout_0, dout_1, coll_cnt);
      idle();
   endtask

   task automatic test_reset_wins();
      cs_0 = 1; we_0 = 1; addr_0 = 4'd4; din_0 = 8'h66;
      cyc();
      rst_n = 0;
      cs_0 = 1; we_0 = 1; addr_0 = 4'd4; din_0 = 8'h77;
      cyc();
      checks++; if (coll_cnt !== 8'd0) begin errors++; $display("FAIL rst_coll_cnt got %0d exp 0", coll_cnt); end
      checks++; if (dout_0 !== 8'h00) begin errors++; $display("FAIL rst_dout_0 got %h exp 00", dout_0); end
      idle(); rst_n = 1;
`ifdef RAM_TDP_INIT_CLEAR_EN
      for (int i = 0; i < DEPTH + 1; i++) cyc();
`else
      cyc();
`endif
      cs_0 = 1; we_0 = 0; addr_0 = 4'd4;
      cyc();
`ifdef RAM_TDP_INIT_CLEAR_EN
      checks++; if (dout_0 !== 8'hFF) begin errors++; $display("FAIL rst_wins_read got %h exp FF", dout_0); end
`else
      checks++; if (dout_0 !== 8'h66) begin errors++; $display("FAIL rst_wins_read got %h exp 66", dout_0); end
`endif
      $display("reset_wins: addr 4 = %h", dout_0);
      idle();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 260; i++) begin
         cs_0 = 1; we_0 = 1; addr_0 = 4'd6; din_0 = 8'(i);
         cs_1 = 1; we_1 = 1; addr_1 = 4'd6; din_1 = 8'hC3;
         cyc();
         if (i == 253) begin
            checks++; if (coll_cnt !== 8'd254) begin errors++; $display("FAIL sat_cnt_254 got %0d exp 254", coll_cnt); end
         end
      end
      checks++; if (coll_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt_255 got %0d exp 255", coll_cnt); end
      checks++; if (collision !== 1'b1) begin errors++; $display("FAIL sat_collision got %b exp 1", collision); end
      idle();
      cs_0 = 1; we_0 = 0; addr_0 = 4'd6;
      cyc();
      checks++; if (dout_0 !== 8'd3) begin errors++; $display("FAIL sat_priority_data got %h exp 03", dout_0); end
      checks++; if (coll_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", coll_cnt); end
      $display("saturation: 260 collisions cnt=%0d", coll_cnt);
      idle();
   endtask

   initial begin
      idle();
      oe_0 = 0; oe_1 = 0; rst_n = 0;
      test_reset();
`ifdef RAM_TDP_INIT_CLEAR_EN
      test_clear();
      test_clear_restart();
`else
      test_release();
`endif
      test_write_read();
      test_write_write();
      test_read_during_write();
      test_back_to_back();
      test_reset_wins();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_tdp_csoe_resp.md
Name: ram_tdp_csoe_resp

Overview:
- Responder end of the dual-port CS/OE RAM bus: a true dual-port synchronous RAM with two symmetric ports (0 and 1).
- Each port has chip-select, output-enable, write-enable, address, write data and read data.
- Block adds same-address collision resolution, a collision event counter and a post-reset ready handshake.
- Sits under the testbench driver/monitor as the DUT side of the RAM interface.

Parameters:
AWIDTH, 4, address width; DEPTH = 2**AWIDTH words
DWIDTH, 8, data width
CNT_WIDTH, 8, width of collision counter
WR_PRIORITY, 0, port whose write wins on a same-address double write (0 or 1)
INIT_VALUE, 0, word written by optional clear sequence (DWIDTH bits)

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
cs_0  input  1  port 0 chip select
oe_0  input  1  port 0 output enable
we_0  input  1  port 0 write enable (1 write, 0 read)
addr_0  input  AWIDTH  port 0 address
din_0  input  DWIDTH  port 0 write data
dout_0  output  DWIDTH  port 0 read data
cs_1  input  1  port 1 chip select
oe_1  input  1  port 1 output enable
we_1  input  1  port 1 write enable
addr_1  input  AWIDTH  port 1 address
din_1  input  DWIDTH  port 1 write data
dout_1  output  DWIDTH  port 1 read data
ready  output  1  1 = accesses accepted
collision  output  1  one-cycle pulse on a same-address conflict
coll_cnt  output  CNT_WIDTH  saturating count of collisions

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n). Reset is sampled only on posedge clk.
- Reset values:
  - rd_data_0/1 registers = 0, so dout_0/1 = 0.
  - collision = 0, coll_cnt = 0.
  - ready = 0 while rst_n = 0.
  - Memory contents are not cleared, except with the optional feature.
- FSM states: RESET, CLEAR, READY.
  - RESET -> READY on the first edge with rst_n = 1 (feature off).
  - RESET -> CLEAR on the first edge with rst_n = 1 (feature on).
  - ready = 1 only in READY.
  - rst_n = 0 in any state -> RESET on that edge, including mid-CLEAR.
- Access is qualified per port by acc_x = ready & cs_x.
  - Accesses with ready = 0 are ignored: no write, rd_data holds.
- Write: acc_x & we_x at edge N -> mem[addr_x] <= din_x at edge N.
- Read: acc_x & !we_x at edge N -> rd_data_x <= mem[addr_x] (pre-edge contents) at edge N.
  - Data is visible after edge N and sampled by the bench at edge N+1, i.e. 1-cycle latency.
  - rd_data_x holds its value when there is no read.
- Output: dout_x = oe_x ? rd_data_x : 0 (combinational gate, no tristate).
  - cs_x does not affect dout_x; oe_x may be raised any later cycle to read held data.
- Collision condition at an edge: acc_0 & acc_1 & addr_0 == addr_1 & (we_0 | we_1).
  - Write/write: only port WR_PRIORITY's din is stored.
  - Write/read: the reader gets old data (read-before-write); the write completes normally.
  - Read/read, or different addresses: no collision, both serviced independently.
  - On a collision: collision = 1 for exactly the following cycle (registered).
  - On a collision: coll_cnt increments by 1, saturating at 2**CNT_WIDTH-1 with no wrap.
- Simultaneous reset and access: reset wins; no memory write occurs on that edge.

Optional Feature:
- Macro RAM_TDP_INIT_CLEAR_EN.
- Defined:
  - CLEAR state walks clr_addr 0..DEPTH-1, writing INIT_VALUE one word per cycle.
  - After writing DEPTH-1 it moves to READY, so ready rises DEPTH+1 edges after rst_n deasserts.
  - Port inputs are ignored during CLEAR.
  - Reset mid-CLEAR restarts the sequence at address 0.
- Undefined:
  - CLEAR state, clr_addr and INIT_VALUE logic are absent.
  - Memory is uninitialised (X) until written.

Test Plan:
- Reset, then port 0 writes 0xA5 to addr 3; port 1 reads addr 3 next cycle with oe_1 = 1 -> dout_1 = 0xA5 one cycle after the read; dout_1 = 0x00 when oe_1 = 0.
- Both ports write addr 7 in the same cycle (port 0 = 0x11, port 1 = 0x22), WR_PRIORITY = 0 -> a read of addr 7 returns 0x11; collision pulses 1 cycle; coll_cnt = 1.
- Addr 5 preloaded with 0x33; port 0 writes 0x44 to addr 5 while port 1 reads addr 5 -> dout_1 = 0x33; a following read returns 0x44; coll_cnt increments.
- Both ports read addr 2 (0x5A) and write distinct addresses 1 and 9 concurrently -> no collision, coll_cnt unchanged, all data correct.
- Force 260 collisions with CNT_WIDTH = 8 -> coll_cnt stops at 255.
- RAM_TDP_INIT_CLEAR_EN defined, INIT_VALUE = 0xFF:
  - Release reset -> ready = 0 for 16 cycles, then every address reads 0xFF.
  - Assert rst_n = 0 at clear address 8 -> ready = 0 and the clear restarts from address 0.
